// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - alarm states, LED encodings and ladder-word helpers for level_alarm_ctrl
//
// Contents:
//   alarm_state_t  : NORMAL / LOW / HIGH / FAULT (2-bit encoding seen on alarm_state)
//   LED_*          : LED pattern per state, bit 0 LOW, bit 1 NORMAL, bit 2 HIGH
//   led_of         : state -> LED pattern
//   thermo_valid   : word has the form 0..01..1 (all-zero and all-one included)
//   popcount       : number of set bits
// The helpers take a WORD_MAX-bit argument; callers zero-extend their N-bit word,
// so any ladder up to WORD_MAX sensors is supported.

package level_pkg;

    typedef enum logic [1:0] {
        ALARM_NORMAL = 2'd0,
        ALARM_LOW    = 2'd1,
        ALARM_HIGH   = 2'd2,
        ALARM_FAULT  = 2'd3
    } alarm_state_t;

    localparam logic [2:0] LED_LOW    = 3'b001;
    localparam logic [2:0] LED_NORMAL = 3'b010;
    localparam logic [2:0] LED_HIGH   = 3'b100;
    localparam logic [2:0] LED_FAULT  = 3'b111;

    localparam int WORD_MAX = 64;

    function automatic logic [2:0] led_of(input alarm_state_t s);
        logic [2:0] led;
        case (s)
            ALARM_LOW:   led = LED_LOW;
            ALARM_HIGH:  led = LED_HIGH;
            ALARM_FAULT: led = LED_FAULT;
            default:     led = LED_NORMAL;
        endcase
        return led;
    endfunction

    // A zero-extended thermometer word plus one is a power of two (or zero for
    // an all-ones WORD_MAX word), so it shares no set bit with the word itself.
    function automatic logic thermo_valid(input logic [WORD_MAX-1:0] w);
        return (w & (w + WORD_MAX'(1))) == '0;
    endfunction

    function automatic logic [6:0] popcount(input logic [WORD_MAX-1:0] w);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < WORD_MAX; i++) begin
            n = n + 7'(w[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/level_alarm_ctrl_if.sv
// rtl/level_alarm_ctrl_if.sv - board-side signal bundle of level_alarm_ctrl
//
// Raw inputs:  sensors_input, setup_input (N_SENSORS each), saveH_button, saveL_button
// Outputs:     level, thr_high, thr_low (LW each), alarm_state (2), LED (3), fault, save_err
// Modports:    master - board / display side (drives raw inputs, reads status)
//              slave  - the level_alarm_ctrl core

interface level_alarm_ctrl_if #(
    parameter int N_SENSORS = 8
);
    localparam int LW = $clog2(N_SENSORS + 1);

    logic [N_SENSORS-1:0] sensors_input;
    logic [N_SENSORS-1:0] setup_input;
    logic                 saveH_button;
    logic                 saveL_button;

    logic [LW-1:0]        level;
    logic [LW-1:0]        thr_high;
    logic [LW-1:0]        thr_low;
    logic [1:0]           alarm_state;
    logic [2:0]           LED;
    logic                 fault;
    logic                 save_err;

    modport master (
        output sensors_input, setup_input, saveH_button, saveL_button,
        input  level, thr_high, thr_low, alarm_state, LED, fault, save_err
    );

    modport slave (
        input  sensors_input, setup_input, saveH_button, saveL_button,
        output level, thr_high, thr_low, alarm_state, LED, fault, save_err
    );

endinterface

// File: rtl/level_debounce.sv
// rtl/level_debounce.sv - 2-flop synchroniser followed by a W-bit debouncer
//
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, clears every stage to 0
//   din  : raw asynchronous input word
//   dout : debounced word; follows din 2 + CYCLES cycles after a stable change
// Parameters: W (word width), CYCLES (consecutive equal samples required)

module level_debounce #(
    parameter int W      = 1,
    parameter int CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int           CW       = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLES);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  cand;
    logic [W-1:0]  stable;
    logic [CW-1:0] cnt;

    // The sample that changes the candidate is itself the first equal sample,
    // so the counter restarts at one; it saturates once the run is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_ONE;
                if (CYCLES == 1) begin
                    stable <= sync2;
                end
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    stable <= cand;
                end
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/level_alarm_ctrl.sv
// rtl/level_alarm_ctrl.sv - N-sensor level decode, threshold store and hysteretic alarm FSM
//
// Ports:
//   clk_100MHz   : system clock
//   reset_button : synchronous active-high reset
//   bus          : level_alarm_ctrl_if.slave (raw sensors/setup/save inputs,
//                  level, thresholds, alarm_state, LED, fault, save_err outputs)
// Parameters: N_SENSORS (<= WORD_MAX), DEBOUNCE_CYCLES, HYST
// Build option: LEVEL_FAULT_LATCH_EN - when defined, FAULT is left only through reset.

module level_alarm_ctrl
    import level_pkg::*;
#(
    parameter int N_SENSORS       = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HYST            = 1
) (
    input  logic              clk_100MHz,
    input  logic              reset_button,
    level_alarm_ctrl_if.slave bus
);

    localparam int LW  = $clog2(N_SENSORS + 1);
    localparam int LWX = LW + 1;
    localparam logic [LWX-1:0] HYST_X = LWX'(HYST);

    logic [N_SENSORS-1:0] sens_db;
    logic [N_SENSORS-1:0] setup_db;
    logic                 save_h_db;
    logic                 save_l_db;

    logic [LW-1:0] level_q;
    logic [LW-1:0] thr_high_q;
    logic [LW-1:0] thr_low_q;
    alarm_state_t  state_q;
    alarm_state_t  state_n;
    logic [2:0]    led_q;
    logic          fault_q;
    logic          save_err_q;
    logic          save_h_prev;
    logic          save_l_prev;

    level_debounce #(.W(N_SENSORS), .CYCLES(DEBOUNCE_CYCLES)) u_db_sensors (
        .clk  (clk_100MHz),
        .rst  (reset_button),
        .din  (bus.sensors_input),
        .dout (sens_db)
    );

    level_debounce #(.W(N_SENSORS), .CYCLES(DEBOUNCE_CYCLES)) u_db_setup (
        .clk  (clk_100MHz),
        .rst  (reset_button),
        .din  (bus.setup_input),
        .dout (setup_db)
    );

    level_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_save_h (
        .clk  (clk_100MHz),
        .rst  (reset_button),
        .din  (bus.saveH_button),
        .dout (save_h_db)
    );

    level_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_db_save_l (
        .clk  (clk_100MHz),
        .rst  (reset_button),
        .din  (bus.saveL_button),
        .dout (save_l_db)
    );

    logic          sens_ok;
    logic          setup_ok;
    logic [LW-1:0] sens_level;
    logic [LW-1:0] cand;
    logic          rise_h;
    logic          rise_l;

    assign sens_ok    = thermo_valid(WORD_MAX'(sens_db));
    assign setup_ok   = thermo_valid(WORD_MAX'(setup_db));
    assign sens_level = LW'(popcount(WORD_MAX'(sens_db)));
    assign cand       = LW'(popcount(WORD_MAX'(setup_db)));
    assign rise_h     = save_h_db & ~save_h_prev;
    assign rise_l     = save_l_db & ~save_l_prev;

    // Hysteresis bounds are one bit wider than a level so thr_low + HYST cannot
    // wrap; the explicit guard keeps thr_high - HYST from wrapping below zero.
    logic [LWX-1:0] level_x;
    logic [LWX-1:0] thr_high_x;
    logic [LWX-1:0] thr_low_x;
    logic           high_exit;
    logic           low_exit;

    assign level_x    = {1'b0, level_q};
    assign thr_high_x = {1'b0, thr_high_q};
    assign thr_low_x  = {1'b0, thr_low_q};
    assign high_exit  = (thr_high_x >= HYST_X) && (level_x <= (thr_high_x - HYST_X));
    assign low_exit   = level_x >= (thr_low_x + HYST_X);

    // A bubble in the debounced ladder overrides every other transition. The
    // bubble is taken straight from the debounced word, so FAULT is entered on
    // the same edge that would otherwise have updated level.
    always_comb begin
        state_n = state_q;
        if (!sens_ok) begin
            state_n = ALARM_FAULT;
        end else begin
            case (state_q)
                ALARM_NORMAL: begin
                    if (level_q > thr_high_q) begin
                        state_n = ALARM_HIGH;
                    end else if (level_q < thr_low_q) begin
                        state_n = ALARM_LOW;
                    end
                end
                ALARM_HIGH: begin
                    // A drop below thr_low still passes through NORMAL first.
                    if (high_exit) begin
                        state_n = ALARM_NORMAL;
                    end
                end
                ALARM_LOW: begin
                    if (level_q > thr_high_q) begin
                        state_n = ALARM_HIGH;
                    end else if (low_exit) begin
                        state_n = ALARM_NORMAL;
                    end
                end
                ALARM_FAULT: begin
`ifdef LEVEL_FAULT_LATCH_EN
                    state_n = ALARM_FAULT;
`else
                    state_n = ALARM_NORMAL;
`endif
                end
                default: state_n = ALARM_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset_button) begin
            level_q     <= '0;
            thr_high_q  <= LW'(N_SENSORS);
            thr_low_q   <= '0;
            state_q     <= ALARM_NORMAL;
            led_q       <= LED_NORMAL;
            fault_q     <= 1'b0;
            save_err_q  <= 1'b0;
            save_h_prev <= 1'b0;
            save_l_prev <= 1'b0;
        end else begin
            save_h_prev <= save_h_db;
            save_l_prev <= save_l_db;

            if (sens_ok) begin
                level_q <= sens_level;
            end

            state_q <= state_n;
            led_q   <= led_of(state_n);
            fault_q <= (state_n == ALARM_FAULT);

            save_err_q <= 1'b0;
            if (rise_h && rise_l) begin
                // Ambiguous request: neither threshold moves.
                save_err_q <= 1'b1;
            end else if (rise_h) begin
                if (setup_ok && (cand > thr_low_q)) begin
                    thr_high_q <= cand;
                end else begin
                    save_err_q <= 1'b1;
                end
            end else if (rise_l) begin
                if (setup_ok && (cand < thr_high_q)) begin
                    thr_low_q <= cand;
                end else begin
                    save_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.thr_high    = thr_high_q;
    assign bus.thr_low     = thr_low_q;
    assign bus.alarm_state = state_q;
    assign bus.LED         = led_q;
    assign bus.fault       = fault_q;
    assign bus.save_err    = save_err_q;

endmodule

// File: tb/tb_level_alarm_ctrl.sv
// tb/tb_level_alarm_ctrl.sv - scoreboard bench for level_alarm_ctrl with a step-level reference model

module tb_level_alarm_ctrl;

    localparam int N      = 8;
    localparam int C      = 4;
    localparam int HYST   = 1;
    localparam int SETTLE = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_alarm_ctrl_if #(.N_SENSORS(N)) bus ();

    level_alarm_ctrl #(.N_SENSORS(N), .DEBOUNCE_CYCLES(C), .HYST(HYST)) dut (
        .clk_100MHz   (clk),
        .reset_button (rst),
        .bus          (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {level, thr_high, thr_low, alarm_state, LED, fault, save_err}
    logic [18:0] dut_v;
    assign dut_v = {bus.level, bus.thr_high, bus.thr_low, bus.alarm_state, bus.LED, bus.fault, bus.save_err};

    typedef struct {
        int          cyc;
        logic [18:0] v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;
    logic [18:0] mon_prev;

    // Reference model state, updated once per stimulus step.
    int          m_lvl;
    int          m_th;
    int          m_tl;
    int          m_st;
    bit          m_bub;
    logic [7:0]  m_setup;
    logic [18:0] m_last;

    function automatic bit is_thermo(input logic [7:0] w);
        bit seen_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!w[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int ones(input logic [7:0] w);
        int n = 0;
        for (int i = 0; i < 8; i++) if (w[i]) n++;
        return n;
    endfunction

    function automatic logic [18:0] pack_model(input bit err);
        logic [2:0] led;
        case (m_st)
            0:       led = 3'b010;
            1:       led = 3'b001;
            2:       led = 3'b100;
            default: led = 3'b111;
        endcase
        return {4'(m_lvl), 4'(m_th), 4'(m_tl), 2'(m_st), led, (m_st == 3), err};
    endfunction

    function automatic void push(input int c, input bit err);
        logic [18:0] v = pack_model(err);
        if (v !== m_last) begin
            exp_q.push_back('{cyc: c, v: v});
            m_last = v;
        end
    endfunction

    // One alarm decision: 0 NORMAL, 1 LOW, 2 HIGH, 3 FAULT.
    function automatic int alarm_next(input int s, input int lvl, input int th, input int tl, input bit bub);
        if (bub) return 3;
        case (s)
            3: begin
`ifdef LEVEL_FAULT_LATCH_EN
                return 3;
`else
                return 0;
`endif
            end
            0: begin
                if (lvl > th) return 2;
                if (lvl < tl) return 1;
                return 0;
            end
            2: return (lvl <= th - HYST) ? 0 : 2;
            1: begin
                if (lvl > th) return 2;
                if (lvl >= tl + HYST) return 0;
                return 1;
            end
            default: return 0;
        endcase
    endfunction

    function automatic void settle(input int c);
        for (int i = 0; i < 4; i++) begin
            int ns = alarm_next(m_st, m_lvl, m_th, m_tl, m_bub);
            if (ns == m_st) break;
            m_st = ns;
            push(c + i, 1'b0);
        end
    endfunction

    // Sensor word applied after edge t: debounced at t+6, level/FAULT at t+7,
    // alarm decisions on the new level from t+8.
    function automatic void model_sensor(input int t, input logic [7:0] w);
        int old_lvl = m_lvl;
        m_bub = !is_thermo(w);
        if (!m_bub) m_lvl = ones(w);
        m_st = alarm_next(m_st, old_lvl, m_th, m_tl, m_bub);
        push(t + 7, 1'b0);
        settle(t + 8);
    endfunction

    // kind 0 saveH, 1 saveL, 2 both; press applied after edge t.
    function automatic void model_save(input int t, input int kind);
        int cand = ones(m_setup);
        bit ok   = is_thermo(m_setup);
        bit err  = 1'b0;
        if (kind == 2) err = 1'b1;
        else if (kind == 0) begin
            if (ok && cand > m_tl) m_th = cand;
            else err = 1'b1;
        end else begin
            if (ok && cand < m_th) m_tl = cand;
            else err = 1'b1;
        end
        push(t + 7, err);
        m_st = alarm_next(m_st, m_lvl, m_th, m_tl, m_bub);
        push(t + 8, 1'b0);
        settle(t + 9);
    endfunction

    function automatic void model_reset();
        m_lvl = 0;
        m_th  = N;
        m_tl  = 0;
        m_st  = 0;
        m_bub = 1'b0;
    endfunction

    task automatic sensor_step(input logic [7:0] w);
        @(posedge clk); #1;
        bus.sensors_input = w;
        model_sensor(cyc, w);
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic setup_step(input logic [7:0] w);
        @(posedge clk); #1;
        bus.setup_input = w;
        m_setup = w;
        repeat (10) @(posedge clk);
    endtask

    task automatic save_step(input int kind);
        @(posedge clk); #1;
        if (kind != 1) bus.saveH_button = 1'b1;
        if (kind != 0) bus.saveL_button = 1'b1;
        model_save(cyc, kind);
        repeat (8) @(posedge clk); #1;
        bus.saveH_button = 1'b0;
        bus.saveL_button = 1'b0;
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic glitch_step(input logic [7:0] w, input int g);
        logic [7:0] orig;
        @(posedge clk); #1;
        orig = bus.sensors_input;
        bus.sensors_input = w;
        repeat (g) @(posedge clk); #1;
        bus.sensors_input = orig;
        repeat (SETTLE) @(posedge clk);
    endtask

    // New sensor word, then reset k cycles later (before it can debounce), held r cycles.
    task automatic reset_step(input logic [7:0] w, input int k, input int r);
        int t;
        @(posedge clk); #1;
        bus.sensors_input = w;
        if (k > 0) begin
            repeat (k) @(posedge clk); #1;
        end
        rst = 1'b1;
        t = cyc;
        model_reset();
        push(t + 1, 1'b0);
        repeat (r) @(posedge clk); #1;
        rst = 1'b0;
        model_sensor(cyc, w);
        repeat (SETTLE) @(posedge clk);
    endtask

    function automatic logic [7:0] rand_valid();
        int k = $urandom_range(0, 8);
        return 8'((1 << k) - 1);
    endfunction

    function automatic logic [7:0] rand_bubble();
        logic [7:0] w;
        do w = 8'($urandom); while (is_thermo(w));
        return w;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_event cycle %0d: outputs %h, required %h from cycle %0d", cyc, dut_v, mon_e.v, mon_e.cyc);
            end
            if (dut_v !== mon_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cycle %0d: outputs %h, required %h unchanged", cyc, dut_v, mon_prev);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.v !== dut_v) begin
                        n_bad++;
                        $display("FAIL output_event: got %h at cycle %0d, required %h at cycle %0d", dut_v, cyc, mon_e.v, mon_e.cyc);
                    end
                end
                mon_prev = dut_v;
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit reached before end of stimulus");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    logic [7:0] rw;
    int         op;

    initial begin
        bus.sensors_input = '0;
        bus.setup_input   = '0;
        bus.saveH_button  = 1'b0;
        bus.saveL_button  = 1'b0;
        model_reset();
        m_setup = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dut_v !== pack_model(1'b0)) begin
            n_bad++;
            $display("FAIL reset_state: got %h, required %h", dut_v, pack_model(1'b0));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        m_last   = pack_model(1'b0);
        mon_prev = pack_model(1'b0);
        mon_en   = 1'b1;

        setup_step(8'b0111_1111); save_step(0);
        setup_step(8'b0000_1111); save_step(1);
        sensor_step(8'hFF);
        sensor_step(8'h3F);
        sensor_step(8'h07);
        sensor_step(8'h0F);
        sensor_step(8'h1F);
        sensor_step(8'b0100_0111);
        sensor_step(8'h07);
        setup_step(8'hFF); save_step(1);
        setup_step(8'b0010_1011); save_step(0);
        setup_step(8'h0F); save_step(2);
        glitch_step(8'hFF, 3);
        sensor_step(8'hFF);
        reset_step(8'h3F, 2, 1);
        sensor_step(8'hFF);
        reset_step(8'hFF, 0, 2);

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                rw = ($urandom_range(0, 3) == 0) ? rand_bubble() : rand_valid();
                sensor_step(rw);
            end else if (op == 4) begin
                rw = ($urandom_range(0, 4) == 0) ? rand_bubble() : rand_valid();
                setup_step(rw);
            end else if (op <= 6) begin
                save_step($urandom_range(0, 2));
            end else if (op <= 8) begin
                glitch_step(8'($urandom), $urandom_range(1, C - 1));
            end else begin
                rw = ($urandom_range(0, 3) == 0) ? rand_bubble() : rand_valid();
                reset_step(rw, $urandom_range(0, 4), $urandom_range(1, 3));
            end
        end

        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d still queued, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/level_alarm_ctrl.md
# level_alarm_ctrl

Parametrised level-measurement and alarm core for the liquid level meter. It replaces the fixed 8-sensor path with an N-sensor path. It debounces the sensor, setup and save inputs, decodes the thermometer-coded sensor ladder into a level count, and stores validated high/low thresholds. A hysteretic alarm state machine drives the three status LEDs. It sits between the board inputs and the 7-segment display driver, which consumes `level`, `thr_high` and `thr_low`.

## Interface
- `N_SENSORS`, 8: number of ladder sensors; bit 0 is the bottom sensor.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive equal samples required before a debounced value changes (10 ms at 100 MHz).
- `HYST`, 1: hysteresis, in levels, applied on alarm exit.
- `LW`, $clog2(N_SENSORS+1): width of level values (derived; do not override).

Ports:
- `clk_100MHz`  in  1  system clock.
- `reset_button`  in  1  synchronous, active-high reset.
- `sensors_input`  in  N_SENSORS  raw asynchronous sensor ladder.
- `setup_input`  in  N_SENSORS  raw switch word, thermometer-coded, giving the threshold candidate.
- `saveH_button`  in  1  raw request to store the high threshold.
- `saveL_button`  in  1  raw request to store the low threshold.
- `level`  out  LW  current valid level (popcount of the ladder).
- `thr_high`  out  LW  stored high threshold.
- `thr_low`  out  LW  stored low threshold.
- `alarm_state`  out  2  0 NORMAL, 1 LOW, 2 HIGH, 3 FAULT.
- `LED`  out  3  [0] LOW, [1] NORMAL, [2] HIGH; all three set in FAULT.
- `fault`  out  1  high while in FAULT.
- `save_err`  out  1  one-cycle pulse when a save request is rejected.

## Operation
- Every raw input passes through a 2-flop synchroniser, then a debouncer.
- Debouncer:
  - A counter clears whenever the synced sample differs from the candidate.
  - The stable output takes the candidate once DEBOUNCE_CYCLES consecutive equal samples have been seen.
  - There is one debouncer per vector and one per button.
- Thermometer check: a word is valid iff it has the form 0…01…1; all-zero and all-one words are valid.
- Level decode:
  - A valid sensor word updates `level` to its popcount.
  - An invalid sensor word (bubble) holds `level` and raises the FAULT condition.
- Save requests act on the rising edge of the debounced button, with cand = popcount of the debounced `setup_input`.
  - saveH is accepted iff setup is valid and cand > thr_low; accepted means thr_high <= cand.
  - saveL is accepted iff setup is valid and cand < thr_high; accepted means thr_low <= cand.
  - A rejected request leaves both thresholds unchanged and pulses `save_err`.
  - saveH and saveL rising edges in the same cycle are both rejected, with a single `save_err` pulse.
- Alarm FSM, evaluated every cycle with the current registered level and thresholds:
  - Any state with a bubble goes to FAULT; this has priority over all other transitions.
  - NORMAL goes to HIGH if level > thr_high, or to LOW if level < thr_low.
  - HIGH goes to NORMAL if level <= thr_high - HYST; a HIGH-to-LOW jump also goes through this check first.
  - LOW goes to NORMAL if level >= thr_low + HYST. LOW goes directly to HIGH if level > thr_high.
  - FAULT goes to NORMAL once the sensor word is valid again; see Configuration.
- Hysteresis arithmetic is computed in LW+1 bits. This keeps thr_low + HYST from overflowing and thr_high - HYST from underflowing; the comparisons are unsigned.
- Reset values:
  - level = 0, thr_high = N_SENSORS, thr_low = 0.
  - alarm_state = NORMAL, LED = 3'b010, fault = 0, save_err = 0.
  - All synchronisers, debouncers and counters clear to 0.
- Reset asserted mid-operation abandons debounce progress and any pending save, and returns all outputs to their reset values on the next edge.

## Timing
- Input change to debounced change: 2 + DEBOUNCE_CYCLES cycles.
- Debounced change to `level`: 1 cycle.
- `level` to `alarm_state`/`LED`/`fault`: 1 cycle.
- Debounced save edge to threshold update or `save_err`: 1 cycle.
- Bounce shorter than DEBOUNCE_CYCLES never reaches the decoder.
- All outputs are registered.

## Configuration
- `LEVEL_FAULT_LATCH_EN`:
  - Defined: FAULT is sticky and exits only via `reset_button`.
  - Undefined: FAULT returns to NORMAL one cycle after the debounced sensor word is valid. The FSM then re-evaluates normally from the next cycle.

## Structure
- Package `level_pkg` holds:
  - The alarm state constants (NORMAL/LOW/HIGH/FAULT).
  - The LED encodings per state.
  - The thermometer-valid and popcount functions.
- Sub-module `level_debounce #(W, CYCLES)` combines the synchroniser and debouncer. It is instantiated for the sensors vector, the setup vector and each button.

## Test plan
Run with DEBOUNCE_CYCLES = 4, N_SENSORS = 8, HYST = 1.
- Save thresholds: setup = 8'b0111_1111 with a saveH pulse, then 8'b0000_1111 with a saveL pulse. Expect thr_high = 7, thr_low = 4, no `save_err`.
- Alarm entry and exit: sensors = 8'hFF gives level 8, HIGH, LED = 3'b100. Sensors = 8'h3F gives level 6 <= 7-1, NORMAL. Sensors = 8'h07 gives LOW, LED = 3'b001. Sensors = 8'h0F gives 4 < 5, stays LOW. Sensors = 8'h1F gives NORMAL.
- Bubble: sensors = 8'b0100_0111 gives FAULT, LED = 3'b111, level holds. Then sensors = 8'h07:
  - Without the macro: NORMAL, then LOW.
  - With the macro: stays FAULT until reset.
- Save rejects:
  - saveL with setup = 8'hFF when thr_high = 7 gives `save_err` and no change.
  - A bubbled setup word gives `save_err`.
  - Simultaneous saveH and saveL give one `save_err`.
- Debounce: a 3-cycle glitch on sensors gives no level change. A sensor change held 4+ cycles changes level exactly 2+4+1 cycles after the input change.
- Reset mid-debounce and while in HIGH: all outputs take their reset values on the next edge, and thr_high = 8.
